// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with one-entry skid,
// branch redirect handling and a sticky imem timeout fault.
// Ports: clk, reset (async, active-high); imem_req/imem_addr out,
//   imem_ack/imem_rdata in; stall_D, pc_src_M, pc_br_M in;
//   inst_F, pc_plus4_F, valid_F, fetch_err out.
// Params: RESET_PC (first fetch address), TIMEOUT (2..255).
// Option: define FETCH_PERF_CNT_EN to add perf_wait_cnt and
//   perf_flush_cnt (32-bit, wrapping) outputs.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_D,
  input  logic        pc_src_M,
  input  logic [31:0] pc_br_M,
  output logic [31:0] inst_F,
  output logic [31:0] pc_plus4_F,
  output logic        valid_F,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_wait_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [7:0]  wait_q, wait_d;

  logic consume, slot_free, redirect;

  assign consume   = valid_q & ~stall_D;
  assign slot_free = ~valid_q | consume;
  assign redirect  = pc_src_M;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      tgt_q       <= '0;
      pend_q      <= 1'b0;
      inst_q      <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      skid_inst_q <= '0;
      skid_pc4_q  <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      pend_q      <= pend_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      skid_inst_q <= skid_inst_d;
      skid_pc4_q  <= skid_pc4_d;
      wait_q      <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    pend_d      = pend_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    skid_inst_d = skid_inst_q;
    skid_pc4_d  = skid_pc4_q;
    wait_d      = wait_q;
    unique case (state_q)
      S_REQ: begin
        if (consume || redirect) valid_d = 1'b0;
        if (imem_ack) begin
          wait_d = '0;
          if (redirect || pend_q) begin
            // response belongs to the flushed path
            pc_d   = redirect ? pc_br_M : tgt_q;
            pend_d = 1'b0;
          end else if (slot_free) begin
            inst_d  = imem_rdata;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end else begin
            skid_inst_d = imem_rdata;
            skid_pc4_d  = pc_q + 32'd4;
            pc_d        = pc_q + 32'd4;
            state_d     = S_HOLD;
          end
        end else begin
          // address must stay put until the ack arrives
          if (redirect) begin
            pend_d = 1'b1;
            tgt_d  = pc_br_M;
          end
          wait_d = wait_q + 8'd1;
          if (wait_d == 8'(TIMEOUT)) begin
            state_d = S_ERR;
            valid_d = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = pc_br_M;
          state_d = S_REQ;
        end else if (slot_free) begin
          inst_d  = skid_inst_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_ERR;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    imem_req   = (state_q == S_REQ);
    imem_addr  = pc_q;
    fetch_err  = (state_q == S_ERR);
    valid_F    = valid_q;
    inst_F     = inst_q;
    pc_plus4_F = pc4_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_wait_q, perf_wait_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [1:0]  flush_n;

  always_comb begin
    flush_n     = 2'd0;
    perf_wait_d = perf_wait_q;
    // a stalled live instruction lost to a redirect
    if (state_q != S_ERR && redirect && valid_q && !consume)
      flush_n = flush_n + 2'd1;
    if (state_q == S_REQ && imem_ack && (redirect || pend_q))
      flush_n = flush_n + 2'd1;
    if (state_q == S_HOLD && redirect)
      flush_n = flush_n + 2'd1;
    if (state_q == S_REQ && !imem_ack)
      perf_wait_d = perf_wait_q + 32'd1;
    perf_flush_d = perf_flush_q + {30'd0, flush_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_wait_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_wait_q  <= perf_wait_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_wait_cnt  = perf_wait_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a latency
// programmable instruction memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_D;
  logic        pc_src_M;
  logic [31:0] pc_br_M;
  logic [31:0] inst_F;
  logic [31:0] pc_plus4_F;
  logic        valid_F;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_wait_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall_D    (stall_D),
    .pc_src_M   (pc_src_M),
    .pc_br_M    (pc_br_M),
    .inst_F     (inst_F),
    .pc_plus4_F (pc_plus4_F),
    .valid_F    (valid_F),
`ifdef FETCH_PERF_CNT_EN
    .perf_wait_cnt  (perf_wait_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mem_lat  = 0;
  bit   mem_en   = 1'b0;
  bit   sb_en    = 1'b0;
  int   consumed = 0;
  int   wcnt     = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory answers on the low phase; ack is seen at the next rise
  always @(negedge clk) begin
    if (mem_en && imem_req && wcnt >= mem_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = word_of(imem_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    if (reset) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_en && !reset && valid_F && !stall_D) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq("sb_inst", inst_F, e.inst);
      check_eq("sb_pc4", pc_plus4_F, e.pc4);
      consumed++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    exp_q.delete();
    consumed = 0;
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back({word_of(a), a + 32'd4});
    end
  endtask

  task automatic wait_consumed(input int n, input int budget,
                               input string tag);
    int c;
    c = 0;
    while (consumed < n && c < budget) begin
      step(1);
      c++;
    end
    check_eq(tag, 32'(consumed >= n), 32'd1);
  endtask

  task automatic pulse_reset();
    sb_en = 1'b0;
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    int c;
    reset    = 1'b1;
    stall_D  = 1'b0;
    pc_src_M = 1'b0;
    pc_br_M  = '0;
    mem_en   = 1'b1;
    step(3);
    check_eq("rst_valid", 32'(valid_F), 32'd0);
    check_eq("rst_inst", inst_F, 32'd0);
    check_eq("rst_pc4", pc_plus4_F, 32'd0);
    check_eq("rst_err", 32'(fetch_err), 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);

    // zero-wait sequential stream
    push_seq(32'd0, 40);
    sb_en = 1'b1;
    reset = 1'b0;
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_valid", 32'(valid_F), 32'd0);
    step(1);
    check_eq("seq0_inst", inst_F, word_of(32'd0));
    check_eq("seq0_pc4", pc_plus4_F, 32'd4);
    step(1);
    check_eq("seq1_pc4", pc_plus4_F, 32'd8);
    step(1);
    check_eq("seq2_pc4", pc_plus4_F, 32'd12);
    check_eq("seq2_valid", 32'(valid_F), 32'd1);
    wait_consumed(12, 14, "seq_progress");

    // decode stall fills the skid and parks in HOLD
    stall_D = 1'b1;
    pulse_reset();
    push_seq(32'd0, 40);
    sb_en = 1'b1;
    reset = 1'b0;
    step(2);
    check_eq("hold_req", 32'(imem_req), 32'd0);
    step(1);
    check_eq("hold_req2", 32'(imem_req), 32'd0);
    check_eq("hold_valid", 32'(valid_F), 32'd1);
    check_eq("hold_inst", inst_F, word_of(32'd0));
    check_eq("hold_addr", imem_addr, 32'd8);
    stall_D = 1'b0;
    wait_consumed(10, 20, "stall_progress");

    // redirect while the first request is still waiting
    mem_lat = 3;
    pulse_reset();
    push_seq(32'h100, 40);
    sb_en    = 1'b1;
    reset    = 1'b0;
    pc_src_M = 1'b1;
    pc_br_M  = 32'h100;
    step(1);
    pc_src_M = 1'b0;
    pc_br_M  = 32'hBAD0;
    check_eq("pend_addr", imem_addr, 32'd0);
    check_eq("pend_valid", 32'(valid_F), 32'd0);
    c = 0;
    while (imem_addr == 32'd0 && c < 10) begin
      step(1);
      c++;
    end
    check_eq("redir_addr", imem_addr, 32'h100);
    wait_consumed(3, 30, "redir_progress");

    // redirect while parked in HOLD
    mem_lat = 0;
    stall_D = 1'b1;
    pulse_reset();
    push_seq(32'h200, 40);
    sb_en = 1'b1;
    reset = 1'b0;
    step(2);
    check_eq("h2_req", 32'(imem_req), 32'd0);
    check_eq("h2_valid", 32'(valid_F), 32'd1);
    pc_src_M = 1'b1;
    pc_br_M  = 32'h200;
    step(1);
    pc_src_M = 1'b0;
    check_eq("h2_flush", 32'(valid_F), 32'd0);
    check_eq("h2_req_again", 32'(imem_req), 32'd1);
    check_eq("h2_addr", imem_addr, 32'h200);
    stall_D = 1'b0;
    wait_consumed(4, 12, "h2_progress");

    // pc wraps modulo 2^32
    pulse_reset();
    push_seq(32'hFFFF_FFF8, 20);
    sb_en    = 1'b1;
    reset    = 1'b0;
    pc_src_M = 1'b1;
    pc_br_M  = 32'hFFFF_FFF8;
    step(1);
    pc_src_M = 1'b0;
    wait_consumed(4, 12, "wrap_progress");

    // no ack at all: timeout fault is sticky until reset
    mem_en = 1'b0;
    pulse_reset();
    reset = 1'b0;
    step(15);
    check_eq("to_early_err", 32'(fetch_err), 32'd0);
    check_eq("to_early_req", 32'(imem_req), 32'd1);
    step(1);
    check_eq("to_err", 32'(fetch_err), 32'd1);
    check_eq("to_req", 32'(imem_req), 32'd0);
    check_eq("to_valid", 32'(valid_F), 32'd0);
    mem_en   = 1'b1;
    pc_src_M = 1'b1;
    pc_br_M  = 32'h40;
    step(3);
    pc_src_M = 1'b0;
    step(1);
    check_eq("to_sticky", 32'(fetch_err), 32'd1);
    check_eq("to_sticky_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("to_clr_err", 32'(fetch_err), 32'd0);
    check_eq("to_clr_req", 32'(imem_req), 32'd1);
    check_eq("to_clr_addr", imem_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 16, REQ cycles without imem_ack before fault (legal 2..255).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 imem_req  out  1  instruction-memory request.
REQ-006 imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
REQ-007 imem_ack  in  1  imem_rdata valid this cycle; completes request.
REQ-008 imem_rdata  in  32  returned instruction word.
REQ-009 stall_D  in  1  decode cannot accept inst_F this cycle.
REQ-010 pc_src_M  in  1  branch redirect from memory stage.
REQ-011 pc_br_M  in  32  redirect target, sampled when pc_src_M=1.
REQ-012 inst_F  out  32  registered instruction to decode.
REQ-013 pc_plus4_F  out  32  registered address of inst_F plus 4.
REQ-014 valid_F  out  1  inst_F/pc_plus4_F hold a live instruction.
REQ-015 fetch_err  out  1  sticky timeout fault.

Function
REQ-016 consume = valid_F & ~stall_D; slot_free = ~valid_F | consume; redirect = pc_src_M.
REQ-017 States REQ, HOLD, ERR; imem_req=1 only in REQ; imem_addr = pc_q.
REQ-018 REQ, ack, no redirect and no pending redirect, slot_free: inst_F<=rdata, pc_plus4_F<=pc_q+4, valid_F<=1, pc_q<=pc_q+4, stay REQ (one instruction per cycle at zero-wait memory).
REQ-019 REQ, ack, not slot_free: rdata and pc_q+4 into one-entry skid, pc_q<=pc_q+4, go HOLD; outputs unchanged.
REQ-020 HOLD: when slot_free, skid moves to outputs with valid_F<=1, go REQ next cycle.
REQ-021 REQ, redirect without ack: pend<=1, tgt<=pc_br_M; imem_addr unchanged; later redirect while pend overwrites tgt.
REQ-022 REQ, ack with redirect or pend: response discarded, pc_q<=(redirect ? pc_br_M : tgt), pend<=0, stay REQ.
REQ-023 Any redirect: valid_F<=0 at next edge regardless of stall_D; in HOLD skid dropped, pc_q<=pc_br_M, go REQ.
REQ-024 Consume without new capture: valid_F<=0.
REQ-025 Wait counter counts REQ cycles without ack, clears on ack; at TIMEOUT go ERR.
REQ-026 ERR: imem_req=0, valid_F=0, fetch_err=1, all inputs ignored until reset.
REQ-027 pc arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-028 On reset: state REQ, pc_q=RESET_PC, valid_F=0, inst_F=0, pc_plus4_F=0, pend=0, tgt=0, skid cleared, wait counter=0, fetch_err=0.
REQ-029 Reset mid-request aborts it; an ack arriving during reset is ignored; first request issued the cycle after reset deasserts with imem_addr=RESET_PC.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: outputs perf_wait_cnt[31:0] (REQ cycles without ack) and perf_flush_cnt[31:0] (discarded responses plus dropped skid/valid_F entries), wrapping, reset to 0.
REQ-031 Macro undefined: both ports and counters absent; all other behaviour identical.

Verification
REQ-032 Zero-wait ack, stall_D=0, RESET_PC=0 -> inst_F words from addrs 0,4,8 on consecutive cycles, pc_plus4_F 4,8,12.
REQ-033 stall_D=1 for 3 cycles after first capture, ack always -> one skid fill, HOLD, no imem_req, no instruction lost or duplicated after release.
REQ-034 Ack delayed 3 cycles, pc_src_M=1 pc_br_M=32'h100 in cycle 1 -> imem_addr held, response dropped, next imem_addr=32'h100.
REQ-035 Redirect in HOLD with valid_F=1 -> valid_F=0 next cycle, skid dropped, next request at pc_br_M.
REQ-036 No ack for 16 REQ cycles -> fetch_err=1, imem_req=0, stays after pc_src_M pulses; reset clears it.
